pcie_cpl_arb: RTL and testbench
===============================

# pcie_cpl_arb

Packet-level round-robin arbiter that shares the single-segment PCIe completion TX stream (tx_cpl_tlp_*) between several completion sources, such as the AXI read-completion path and the write/error completion path. A grant is locked from the SOP beat to the EOP beat, so TLPs never interleave. One output register stage drives tx_cpl_tlp_*. The block sits between the completion generators and the PCIe core TX completion interface.

## Interface
- PORTS, 2: number of completion sources (2..8).
- DATA_WIDTH, 256: TLP payload width per beat.
- STRB_WIDTH, 8: dword strobe width (DATA_WIDTH/32).
- HDR_WIDTH, 128: TLP header width.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_cpl_tlp_data  in  PORTS*DATA_WIDTH  per-port payload; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_cpl_tlp_strb  in  PORTS*STRB_WIDTH  per-port dword strobes.
- s_cpl_tlp_hdr  in  PORTS*HDR_WIDTH  per-port header; only meaningful on SOP beats.
- s_cpl_tlp_valid / s_cpl_tlp_sop / s_cpl_tlp_eop  in  PORTS  per-port beat qualifiers.
- s_cpl_tlp_ready  out  PORTS  per-port beat accept.
- tx_cpl_tlp_data / _strb / _hdr  out  DATA_WIDTH / STRB_WIDTH / HDR_WIDTH  registered output beat.
- tx_cpl_tlp_valid / _sop / _eop  out  1  registered output qualifiers.
- tx_cpl_tlp_ready  in  1  downstream accept.
- cur_grant  out  $clog2(PORTS)  currently or most recently granted port.
- pkt_count  out  32  completed-packet counter.
- err_drop  out  1  one-cycle pulse on each discarded misaligned beat.

## Operation
- Input beat transfer: s_cpl_tlp_valid[i] && s_cpl_tlp_ready[i]. Output beat transfer: tx_cpl_tlp_valid && tx_cpl_tlp_ready.
- The output stage can accept a beat when out_free = !tx_cpl_tlp_valid || tx_cpl_tlp_ready.
- FSM states:
  - IDLE:
    - Candidates are ports with valid && sop.
    - The winner is the first candidate found searching upward from rr_ptr, wrapping modulo PORTS.
    - s_cpl_tlp_ready[winner] = out_free; all other readies are 0.
    - On winner transfer: load the output register, cur_grant <= winner, rr_ptr <= (winner+1) mod PORTS.
    - Go to LOCK unless the beat also carries eop, in which case stay in IDLE.
  - LOCK:
    - s_cpl_tlp_ready[cur_grant] = out_free; all other readies are 0.
    - Each transfer loads the output register.
    - A transfer carrying eop returns the FSM to IDLE.
    - sop asserted on a mid-packet beat is ignored: it is forwarded as-is and the lock is kept.
- Misaligned beats:
  - Applies only in IDLE, with no sop candidate, when at least one port has valid && !sop.
  - The lowest-index such port gets ready=1 regardless of out_free. Its beat is discarded, not forwarded.
  - err_drop pulses on the next edge.
- Output register:
  - Loaded with the granted port's data, strb, hdr, sop and eop on input transfer.
  - tx_cpl_tlp_valid is set on load. It clears on output transfer when no new load occurs in the same cycle.
  - Register contents hold stable while valid && !ready.
- pkt_count increments by 1 on every input transfer with eop that is forwarded. It wraps 0xFFFF_FFFF -> 0.
- Reset values:
  - FSM = IDLE, rr_ptr = 0, cur_grant = 0, pkt_count = 0, err_drop = 0.
  - All tx_cpl_tlp_* = 0.
  - s_cpl_tlp_ready is combinational and is 0 while rst is high.
- Reset mid-packet aborts the lock immediately. Downstream sees valid drop, and the truncated TLP is not completed. Sources must also be reset.

## Timing
- Input-to-output latency: 1 cycle. A beat accepted at edge N is presented on tx_cpl_tlp_* after edge N.
- Throughput is 1 beat/cycle under tx_cpl_tlp_ready=1, including back-to-back packets from the same or different ports. There is no bubble at the LOCK->IDLE boundary, because IDLE arbitrates and accepts in the same cycle.
- s_cpl_tlp_ready depends combinationally on tx_cpl_tlp_ready, the FSM state, cur_grant and the input valid/sop bits. It has no combinational path from the data buses.
- Arbitration is evaluated only in IDLE. A request arriving during LOCK waits until after the EOP transfer.
- Starvation bound: with all ports continuously requesting, each port wins at least once every PORTS packets.
- Simultaneous output drain and load in the same cycle: the register takes the new beat and valid stays 1.

## Test plan
- Single port, PORTS=2: port0 sends 3-beat TLP with hdr=0x1234 and tx_ready=1 -> tx shows sop on beat 1, eop on beat 3, one cycle after each input; pkt_count=1; port1 ready stays 0.
- Contention: both ports present 2-beat TLPs at reset exit with rr_ptr=0 -> order port0, port1, port0, port1; cur_grant toggles; no interleaved beats; 8 output beats in 8 cycles.
- Backpressure: tx_ready held 0 for 5 cycles mid-packet -> tx_cpl_tlp_* hold constant; s_cpl_tlp_ready[grant]=0 after the register fills; no beat lost or duplicated after ready returns.
- Single-beat TLPs: port1 sends sop&eop on 4 consecutive cycles -> 4 output beats, each with sop=eop=1, FSM never enters LOCK, pkt_count=4.
- Misaligned: port0 asserts valid with sop=0 in IDLE -> beat dropped, err_drop high for 1 cycle, no tx valid, pkt_count unchanged.
- Reset/wrap: force pkt_count=0xFFFF_FFFF, then one TLP -> pkt_count=0. Separately, assert rst mid-packet -> all outputs 0 asynchronously; after release, the next TLP from port1 is granted from IDLE.

Source files
------------

// File: rtl/pcie_cpl_arb.sv
// Packet-level round-robin arbiter sharing one PCIe completion TX stream between
// several completion sources; a grant is held from SOP to EOP, one output register.
module pcie_cpl_arb #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = 8,
  parameter int HDR_WIDTH  = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_cpl_tlp_data,
  input  logic [PORTS*STRB_WIDTH-1:0]   s_cpl_tlp_strb,
  input  logic [PORTS*HDR_WIDTH-1:0]    s_cpl_tlp_hdr,
  input  logic [PORTS-1:0]              s_cpl_tlp_valid,
  input  logic [PORTS-1:0]              s_cpl_tlp_sop,
  input  logic [PORTS-1:0]              s_cpl_tlp_eop,
  output logic [PORTS-1:0]              s_cpl_tlp_ready,
  output logic [DATA_WIDTH-1:0]         tx_cpl_tlp_data,
  output logic [STRB_WIDTH-1:0]         tx_cpl_tlp_strb,
  output logic [HDR_WIDTH-1:0]          tx_cpl_tlp_hdr,
  output logic                          tx_cpl_tlp_valid,
  output logic                          tx_cpl_tlp_sop,
  output logic                          tx_cpl_tlp_eop,
  input  logic                          tx_cpl_tlp_ready,
  output logic [$clog2(PORTS)-1:0]      cur_grant,
  output logic [31:0]                   pkt_count,
  output logic                          err_drop
);

  localparam int GW = $clog2(PORTS);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, winner, rr_nxt, sel, mis_port;
  logic            found, mis_found, out_free, fwd, drop;
  int              idx;

  logic [DATA_WIDTH-1:0] data_p0;
  logic [STRB_WIDTH-1:0] strb_p0;
  logic [HDR_WIDTH-1:0]  hdr_p0;
  logic                  vld_p0, sop_p0, eop_p0;

  // Round-robin search for a SOP candidate, plus the lowest misaligned port.
  always_comb begin
    found     = 1'b0;
    winner    = rr_ptr;
    mis_found = 1'b0;
    mis_port  = '0;
    idx       = 0;
    for (int k = 0; k < PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % PORTS;
      if (!found && s_cpl_tlp_valid[idx] && s_cpl_tlp_sop[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (s_cpl_tlp_valid[k] && !s_cpl_tlp_sop[k]) begin
        mis_found = 1'b1;
        mis_port  = GW'(k);
      end
    end
  end

  assign out_free = !vld_p0 || tx_cpl_tlp_ready;
  assign sel      = (state == IDLE) ? winner : cur_grant;
  assign rr_nxt   = (int'(winner) == PORTS - 1) ? '0 : winner + 1'b1;

  always_comb begin
    state_nxt       = state;
    s_cpl_tlp_ready = '0;
    fwd             = 1'b0;
    drop            = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (found) begin
            s_cpl_tlp_ready[winner] = out_free;
            fwd = out_free;
            if (out_free && !s_cpl_tlp_eop[winner]) state_nxt = LOCK;
          end else if (mis_found) begin
            // Stray mid-packet beat with no owner: swallow it so the port cannot wedge.
            s_cpl_tlp_ready[mis_port] = 1'b1;
            drop = 1'b1;
          end
        end
        LOCK: begin
          s_cpl_tlp_ready[cur_grant] = out_free;
          fwd = out_free && s_cpl_tlp_valid[cur_grant];
          if (fwd && s_cpl_tlp_eop[cur_grant]) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register stage (p0) and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_grant <= '0;
      pkt_count <= '0;
      err_drop  <= 1'b0;
      data_p0   <= '0;
      strb_p0   <= '0;
      hdr_p0    <= '0;
      vld_p0    <= 1'b0;
      sop_p0    <= 1'b0;
      eop_p0    <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_drop <= drop;
      if (fwd) begin
        data_p0 <= s_cpl_tlp_data[sel*DATA_WIDTH +: DATA_WIDTH];
        strb_p0 <= s_cpl_tlp_strb[sel*STRB_WIDTH +: STRB_WIDTH];
        hdr_p0  <= s_cpl_tlp_hdr[sel*HDR_WIDTH +: HDR_WIDTH];
        sop_p0  <= s_cpl_tlp_sop[sel];
        eop_p0  <= s_cpl_tlp_eop[sel];
        vld_p0  <= 1'b1;
        if (state == IDLE) begin
          cur_grant <= winner;
          rr_ptr    <= rr_nxt;
        end
        if (s_cpl_tlp_eop[sel]) pkt_count <= pkt_count + 32'd1;
      end else if (tx_cpl_tlp_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign tx_cpl_tlp_data  = data_p0;
  assign tx_cpl_tlp_strb  = strb_p0;
  assign tx_cpl_tlp_hdr   = hdr_p0;
  assign tx_cpl_tlp_valid = vld_p0;
  assign tx_cpl_tlp_sop   = sop_p0;
  assign tx_cpl_tlp_eop   = eop_p0;

endmodule

// File: tb/tb_pcie_cpl_arb.sv
// Self-checking bench for pcie_cpl_arb (PORTS=2): cycle table, directed sequences,
// and a randomized run checked by per-port packet scoreboards.
module tb_pcie_cpl_arb;

  localparam int P  = 2;
  localparam int DW = 256;
  localparam int SW = 8;
  localparam int HW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [P*DW-1:0]   s_cpl_tlp_data;
  logic [P*SW-1:0]   s_cpl_tlp_strb;
  logic [P*HW-1:0]   s_cpl_tlp_hdr;
  logic [P-1:0]      s_cpl_tlp_valid, s_cpl_tlp_sop, s_cpl_tlp_eop, s_cpl_tlp_ready;
  logic [DW-1:0]     tx_cpl_tlp_data;
  logic [SW-1:0]     tx_cpl_tlp_strb;
  logic [HW-1:0]     tx_cpl_tlp_hdr;
  logic              tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_ready;
  logic [0:0]        cur_grant;
  logic [31:0]       pkt_count;
  logic              err_drop;

  pcie_cpl_arb #(.PORTS(P), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW)) dut (
    .clk(clk), .rst(rst),
    .s_cpl_tlp_data(s_cpl_tlp_data), .s_cpl_tlp_strb(s_cpl_tlp_strb), .s_cpl_tlp_hdr(s_cpl_tlp_hdr),
    .s_cpl_tlp_valid(s_cpl_tlp_valid), .s_cpl_tlp_sop(s_cpl_tlp_sop), .s_cpl_tlp_eop(s_cpl_tlp_eop),
    .s_cpl_tlp_ready(s_cpl_tlp_ready),
    .tx_cpl_tlp_data(tx_cpl_tlp_data), .tx_cpl_tlp_strb(tx_cpl_tlp_strb), .tx_cpl_tlp_hdr(tx_cpl_tlp_hdr),
    .tx_cpl_tlp_valid(tx_cpl_tlp_valid), .tx_cpl_tlp_sop(tx_cpl_tlp_sop), .tx_cpl_tlp_eop(tx_cpl_tlp_eop),
    .tx_cpl_tlp_ready(tx_cpl_tlp_ready),
    .cur_grant(cur_grant), .pkt_count(pkt_count), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [HW-1:0] h;
    logic          sop, eop;
  } beat_t;

  typedef struct packed {
    logic [1:0] v, sop, eop;
    logic       txr;
    logic [1:0] rdy;
    logic       txv, txsop, txeop;
    logic [7:0] tag;
    logic       grant, drop;
    logic [7:0] pkts;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    open_port = -1;
  int    drops = 0;
  bit    gap_en = 1'b0;
  bit    acc [P];
  beat_t srcq [P][$];
  beat_t expq [P][$];
  int    out_log[$];
  int    out_cyc[$];
  vec_t  tbl [10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = '0;
      b.d[DW-1 -: 8] = 8'(p);
      b.d[63:0] = {$urandom, $urandom};
      b.s = 8'($urandom);
      b.h = {$urandom, $urandom, $urandom, $urandom};
      b.sop = (k == 0);
      b.eop = (k == len - 1);
      srcq[p].push_back(b);
      expq[p].push_back(b);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_cpl_tlp_valid = '0; s_cpl_tlp_sop = '0; s_cpl_tlp_eop = '0;
    s_cpl_tlp_data = '0; s_cpl_tlp_strb = '0; s_cpl_tlp_hdr = '0;
    tx_cpl_tlp_ready = 1'b0;
    for (int p = 0; p < P; p++) begin
      acc[p] = 1'b0;
      srcq[p].delete();
      expq[p].delete();
    end
    open_port = -1; drops = 0;
    out_log.delete(); out_cyc.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_out();
    int port;
    beat_t e;
    port = int'(tx_cpl_tlp_data[DW-1 -: 8]);
    if (port >= P || expq[port].size() == 0) begin
      chk("out_src", 256'(port), 256'(open_port));
      return;
    end
    if (open_port >= 0) chk("no_interleave", 256'(port), 256'(open_port));
    else                chk("pkt_start_sop", 256'(tx_cpl_tlp_sop), 256'(1));
    e = expq[port].pop_front();
    chk("out_data", tx_cpl_tlp_data, e.d);
    chk("out_ctl", {tx_cpl_tlp_hdr, tx_cpl_tlp_strb, tx_cpl_tlp_sop, tx_cpl_tlp_eop},
        {e.h, e.s, e.sop, e.eop});
    open_port = e.eop ? -1 : port;
    out_log.push_back(port);
    out_cyc.push_back(cyc);
  endtask

  // One cycle: sources and sink are driven at negedge, transfers happen at the next posedge.
  task automatic step(input logic txr);
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      if (acc[p] || !s_cpl_tlp_valid[p]) begin
        acc[p] = 1'b0;
        if (srcq[p].size() > 0 && (!gap_en || ($urandom % 4) != 0)) begin
          s_cpl_tlp_data[p*DW +: DW] = srcq[p][0].d;
          s_cpl_tlp_strb[p*SW +: SW] = srcq[p][0].s;
          s_cpl_tlp_hdr[p*HW +: HW]  = srcq[p][0].h;
          s_cpl_tlp_sop[p] = srcq[p][0].sop;
          s_cpl_tlp_eop[p] = srcq[p][0].eop;
          s_cpl_tlp_valid[p] = 1'b1;
        end else begin
          s_cpl_tlp_valid[p] = 1'b0;
        end
      end
    end
    tx_cpl_tlp_ready = txr;
    #1;
    if (err_drop) drops++;
    if (tx_cpl_tlp_valid && tx_cpl_tlp_ready) check_out();
    for (int p = 0; p < P; p++) begin
      if (s_cpl_tlp_valid[p] && s_cpl_tlp_ready[p]) begin
        void'(srcq[p].pop_front());
        acc[p] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic drain(input string name, input bit rnd, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (expq[0].size() == 0 && expq[1].size() == 0) break;
      step(rnd ? logic'(($urandom % 4) != 0) : 1'b1);
    end
    chk({name, "_left"}, 256'(expq[0].size() + expq[1].size()), 256'(0));
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    int npk;

    tbl[0] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{2'b11, 2'b10, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{2'b11, 2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{2'b10, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'd1};
    tbl[4] = '{2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0, 8'd2};
    tbl[5] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0, 8'd2};
    tbl[6] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 8'd3};
    tbl[7] = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h87, 1'b1, 1'b0, 8'd4};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h87, 1'b1, 1'b1, 8'd4};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h87, 1'b1, 1'b0, 8'd4};

    // Reset state, with requests present while rst is high.
    rst = 1'b1;
    s_cpl_tlp_data = '0; s_cpl_tlp_strb = '0; s_cpl_tlp_hdr = '0;
    s_cpl_tlp_valid = 2'b11; s_cpl_tlp_sop = 2'b11; s_cpl_tlp_eop = 2'b00;
    tx_cpl_tlp_ready = 1'b1;
    #12;
    chk("rst_ready", 256'(s_cpl_tlp_ready), 256'(0));
    chk("rst_tx", {tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_strb}, 256'(0));
    chk("rst_data", tx_cpl_tlp_data, 256'(0));
    chk("rst_hdr", 256'(tx_cpl_tlp_hdr), 256'(0));
    chk("rst_misc", {cur_grant, pkt_count, err_drop}, 256'(0));

    // Cycle table: 3-beat lock, round-robin, backpressure hold, single beats, misaligned drop.
    reset_dut();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      s_cpl_tlp_valid = tbl[r].v;
      s_cpl_tlp_sop   = tbl[r].sop;
      s_cpl_tlp_eop   = tbl[r].eop;
      tx_cpl_tlp_ready = tbl[r].txr;
      for (int p = 0; p < P; p++) s_cpl_tlp_data[p*DW +: DW] = {248'd0, 1'(p), 7'(r + 1)};
      #1;
      chk($sformatf("t%0d_rdy", r), 256'(s_cpl_tlp_ready), 256'(tbl[r].rdy));
      chk($sformatf("t%0d_txv", r), 256'(tx_cpl_tlp_valid), 256'(tbl[r].txv));
      chk($sformatf("t%0d_sopeop", r), 256'({tx_cpl_tlp_sop, tx_cpl_tlp_eop}), 256'({tbl[r].txsop, tbl[r].txeop}));
      chk($sformatf("t%0d_tag", r), tx_cpl_tlp_data, 256'(tbl[r].tag));
      chk($sformatf("t%0d_grant", r), 256'(cur_grant), 256'(tbl[r].grant));
      chk($sformatf("t%0d_drop", r), 256'(err_drop), 256'(tbl[r].drop));
      chk($sformatf("t%0d_pkts", r), 256'(pkt_count), 256'(tbl[r].pkts));
    end

    // Contention: both ports stream 2-beat TLPs from reset exit.
    reset_dut();
    gap_en = 1'b0;
    for (int i = 0; i < 2; i++) begin add_pkt(0, 2); add_pkt(1, 2); end
    drain("cont", 1'b0, 40);
    seq = '0;
    for (int i = 0; i < out_log.size() && i < 8; i++) seq[i] = out_log[i][0];
    chk("cont_order", 256'(seq), 256'(8'b11001100));
    chk("cont_n", 256'(out_log.size()), 256'(8));
    if (out_cyc.size() == 8) chk("cont_rate", 256'(out_cyc[7] - out_cyc[0]), 256'(7));
    chk("cont_pkts", 256'(pkt_count), 256'(4));

    // Backpressure for 5 cycles in the middle of a 4-beat TLP.
    reset_dut();
    add_pkt(0, 4);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("bp_hold", tx_cpl_tlp_data, expq[0][0].d);
      chk("bp_valid", 256'(tx_cpl_tlp_valid), 256'(1));
      chk("bp_ready", 256'(s_cpl_tlp_ready), 256'(0));
    end
    drain("bp", 1'b0, 20);
    step(1'b1);
    chk("bp_pkts", 256'(pkt_count), 256'(1));

    // Four single-beat TLPs back-to-back on port 1.
    reset_dut();
    for (int i = 0; i < 4; i++) add_pkt(1, 1);
    drain("sb", 1'b0, 20);
    step(1'b1);
    chk("sb_n", 256'(out_cyc.size()), 256'(4));
    if (out_cyc.size() == 4) chk("sb_rate", 256'(out_cyc[3] - out_cyc[0]), 256'(3));
    chk("sb_pkts", 256'(pkt_count), 256'(4));

    // Packet counter wrap.
    reset_dut();
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    add_pkt(0, 2);
    drain("wrap", 1'b0, 20);
    step(1'b1);
    chk("wrap_pkts", 256'(pkt_count), 256'(0));

    // Asynchronous reset in the middle of a TLP, then a fresh grant from IDLE.
    reset_dut();
    @(negedge clk);
    s_cpl_tlp_valid = 2'b01; s_cpl_tlp_sop = 2'b01; s_cpl_tlp_eop = 2'b00;
    s_cpl_tlp_data[DW-1:0] = 256'hAB; tx_cpl_tlp_ready = 1'b1;
    @(negedge clk);
    s_cpl_tlp_sop = 2'b00;
    #1;
    chk("mr_pre_valid", 256'(tx_cpl_tlp_valid), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("mr_tx", {tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop}, 256'(0));
    chk("mr_data", tx_cpl_tlp_data, 256'(0));
    chk("mr_ready", 256'(s_cpl_tlp_ready), 256'(0));
    s_cpl_tlp_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    s_cpl_tlp_valid = 2'b10; s_cpl_tlp_sop = 2'b10; s_cpl_tlp_eop = 2'b10;
    s_cpl_tlp_data[2*DW-1:DW] = 256'hCD;
    #1;
    chk("mr_next_ready", 256'(s_cpl_tlp_ready), 256'(2'b10));
    @(negedge clk);
    s_cpl_tlp_valid = 2'b00;
    #1;
    chk("mr_next_out", {tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, cur_grant}, 256'(4'b1111));
    chk("mr_next_data", tx_cpl_tlp_data, 256'hCD);
    chk("mr_pkts", 256'(pkt_count), 256'(1));

    // Randomized traffic with source gaps and random sink backpressure.
    reset_dut();
    gap_en = 1'b1;
    npk = 0;
    for (int i = 0; i < 25; i++) begin
      for (int p = 0; p < P; p++) begin add_pkt(p, int'($urandom_range(1, 4))); npk++; end
    end
    drain("rand", 1'b1, 3000);
    step(1'b1);
    step(1'b1);
    chk("rand_pkts", 256'(pkt_count), 256'(npk));
    chk("rand_drops", 256'(drops), 256'(0));
    chk("rand_open", 256'(open_port + 1), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
